stacker_core: RTL
=================

# stacker_core

Parametrised game engine for the LED-matrix stacker game, generalising the fixed 8x8 stacker to any ROWS x COLS board. It supports a bounce or wrap movement mode, a per-level speed-up and explicit win/lose detection. It sits between the debounced button logic and the matrix driver. It outputs the full frame (`map`), the current `level` for the score display, and game status flags.

## Interface
- `COLS`, 8: columns per row (≥ 2).
- `ROWS`, 8: rows (levels) on the board (≥ 2).
- `START_WIDTH`, 3: initial block width, 1..COLS.
- `BASE_DIV`, 5_000_000: clock cycles per block step at level 0.
- `DIV_STEP`, 500_000: step period reduction per level.
- `MIN_DIV`, 1_000_000: floor on the step period (≥ 1).
- `BOUNCE`, 1: 1 = block reverses at the edges; 0 = row vector rotates left with wrap-around.

- `clk`  in  1  system clock.
- `btnR`  in  1  reset: synchronous, active-high, already debounced.
- `btnS`  in  1  stop/freeze button, already debounced. Active on its rising edge.
- `map`  out  ROWS*COLS  frame. Bit `r*COLS+c` is row r (row 0 = bottom), column c.
- `level`  out  $clog2(ROWS)+1  index of the row currently in play.
- `game_over`  out  1  high in the LOST state.
- `win`  out  1  high in the WON state.

## Operation
- States are PLAY, CHECK, LOST and WON.
- Registers:
  - locked rows `lock[r]`
  - moving row vector `cur` (COLS bits)
  - `width`
  - `dir` (1 = toward higher columns)
  - `level`
  - step counter `cnt`
  - `btnS_d`
- Edge detect: `press = btnS & ~btnS_d`. `btnS_d` resets to 0.
- Reset (`btnR`=1 at a clock edge) sets:
  - state = PLAY, `level`=0, `width`=START_WIDTH
  - `cur` = START_WIDTH ones at columns 0..START_WIDTH-1
  - `dir`=1, `cnt`=0, all `lock` rows = 0
  - `game_over`=0, `win`=0
- Reset overrides everything, including mid-CHECK.
- `map` composition: row r = `lock[r]` for r < `level`, and `cur` for r == `level`. Rows above `level` are 0 in all states.
- Step period P = max(BASE_DIV − `level`*DIV_STEP, MIN_DIV). Compute P without underflow by comparing before subtracting.
- PLAY:
  - `cnt` increments each cycle. When `cnt` == P−1, `cnt` returns to 0 and the block steps.
  - Bounce mode: step shifts `cur` one column in `dir`. If the shifted block would occupy column COLS−1 (moving up) or column 0 (moving down), `dir` flips on that same step. The next step therefore moves away from the edge.
  - Wrap mode: step rotates `cur` left by one, with bit COLS−1 going to bit 0.
  - START_WIDTH == COLS: the block never moves in either mode. `dir` is irrelevant.
  - `press` latches the overlap and moves to CHECK. The overlap is `ov = cur` at level 0, otherwise `ov = cur & lock[level−1]`.
  - `press` has priority over a step in the same cycle: no step occurs that cycle.
- CHECK (exactly one cycle):
  - If `ov` == 0: go to LOST. `cur` is kept as-is so the missed block remains visible.
  - Otherwise set `lock[level]` = `ov`.
  - If `level` == ROWS−1: go to WON.
  - Otherwise:
    - `level`++
    - `width` = popcount(`ov`)
    - `cur` = `width` ones at column 0
    - `dir`=1, `cnt`=0
    - return to PLAY.
  - `press` during CHECK is ignored.
- LOST / WON:
  - `map` is frozen; `cnt` is held.
  - A `press` performs the same initialisation as reset on the next edge.
  - `btnR` also restarts the game.

## Timing
- `press` is seen one cycle after the `btnS` rising edge is registered. CHECK follows on the next edge. Locked row, new `level`, new `cur` and status flags all update at the end of CHECK.
- Press-to-`map`-update latency is therefore 2 clk edges after the edge at which `btnS` is first sampled high.
- First step after reset or after advancing a level occurs P cycles later.
- Holding `btnS` high produces exactly one press. It must go low for at least one cycle to press again.
- `game_over` and `win` are never high together. Both are registered and change only on the CHECK→LOST/WON edge or on restart.

## Test plan
Parameters for all scenarios: COLS=8, ROWS=4, START_WIDTH=3, BASE_DIV=4, DIV_STEP=1, MIN_DIV=2, BOUNCE=1. `map` is shown as 32-bit hex, row 3 in the top byte.

1. Reset, then run 4 cycles -> `map`=0x00000007, then 0x0000000E. Period at level 0 is 4 cycles.
2. Bounce: run from reset with no press -> row 0 goes 07, 0E, 1C, 38, 70, E0, 70, 38. `dir` flips on the 70→E0 step.
3. Press while row 0 = 0x0E -> after CHECK, `map`=0x0000070E and `level`=1. Press immediately again -> `map`=0x0003060E, `level`=2, width 2, next step period 2 cycles.
4. Miss: lock row 0 at 0x07, wait until row 1 = 0xE0, press -> `game_over`=1, `map`=0x0000E007 frozen for 50 cycles. A further press restarts with `map`=0x00000007.
5. Win: press with row 0 = 0x07 and press immediately at every later row -> `win`=1, `map`=0x07070707. `btnR` then returns all outputs to their reset values.
6. Assert `btnS` in the same cycle as a step, and hold it high for 20 cycles -> no step that cycle, exactly one level advance. Also assert `btnR` during CHECK -> reset values on the next edge.

Source files
------------

// File: rtl/stacker_core.sv
// stacker_core: game engine for the LED-matrix stacker game on a ROWS x COLS board.
// A block slides along the active row and the player presses to freeze it.
// The part that overlaps the row below is locked, and the next row starts
// with the width of that overlap. A press that overlaps nothing loses the
// game; locking the top row wins it.
module stacker_core #(
    parameter int COLS        = 8,
    parameter int ROWS        = 8,
    parameter int START_WIDTH = 3,
    parameter int BASE_DIV    = 5_000_000,
    parameter int DIV_STEP    = 500_000,
    parameter int MIN_DIV     = 1_000_000,
    parameter int BOUNCE      = 1
) (
    input  logic                     clk,
    input  logic                     btnR,
    input  logic                     btnS,
    output logic [ROWS*COLS-1:0]     map,
    output logic [$clog2(ROWS):0]    level,
    output logic                     game_over,
    output logic                     win
);

    localparam int LW      = $clog2(ROWS) + 1;
    localparam int WW      = $clog2(COLS + 1);
    localparam int MAX_DIV = (BASE_DIV > MIN_DIV) ? BASE_DIV : MIN_DIV;
    localparam int CW      = $clog2(MAX_DIV + 1);

    typedef enum logic [1:0] {
        S_PLAY,
        S_CHECK,
        S_LOST,
        S_WON
    } state_e;

    // Row vector with the lowest n columns set.
    function automatic logic [COLS-1:0] low_ones(input logic [WW-1:0] n);
        logic [COLS-1:0] res;
        res = '0;
        for (int c = 0; c < COLS; c++) begin
            res[c] = (c < int'(n));
        end
        return res;
    endfunction

    // Number of set columns in a row vector.
    function automatic logic [WW-1:0] popcount(input logic [COLS-1:0] v);
        logic [WW-1:0] res;
        res = '0;
        for (int c = 0; c < COLS; c++) begin
            res = res + WW'(v[c]);
        end
        return res;
    endfunction

    localparam logic [WW-1:0]   START_W   = WW'(START_WIDTH);
    localparam logic [COLS-1:0] START_ROW = low_ones(START_W);

    state_e                     state_q, state_d;
    logic [ROWS-1:0][COLS-1:0]  lock_q, lock_d;
    logic [COLS-1:0]            cur_q, cur_d;
    logic [COLS-1:0]            ov_q, ov_d;
    logic [WW-1:0]              width_q, width_d;
    logic                       dir_q, dir_d;
    logic [LW-1:0]              level_q, level_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic                       game_over_q, game_over_d;
    logic                       win_q, win_d;
    logic                       btn_s_q;
    logic                       btn_prev_q;

    logic                       press;
    logic [31:0]                level_dec;
    logic [31:0]                period;
    logic                       step_due;
    logic [COLS-1:0]            step_row;
    logic                       step_dir;
    logic [COLS-1:0]            prev_row;
    logic [COLS-1:0]            ov_next;
    logic [WW-1:0]              ov_width;

    // A press is the first cycle the registered button sample is high.
    assign press = btn_s_q & ~btn_prev_q;

    // Step period for the current level, clamped at MIN_DIV without underflow.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        period    = 32'(MIN_DIV);
        level_dec = 32'(level_q) * 32'(DIV_STEP);
        if (level_dec < 32'(BASE_DIV)) begin
            if ((32'(BASE_DIV) - level_dec) >= 32'(MIN_DIV)) begin
                period = 32'(BASE_DIV) - level_dec;
            end
        end
        step_due = (32'(cnt_q) == (period - 32'd1));
    end

    // Next position of the moving block and the direction after that move.
    always_comb begin
        step_row = cur_q;
        step_dir = dir_q;
        if (width_q != WW'(COLS)) begin
            if (BOUNCE != 0) begin
                if (dir_q) begin
                    step_row = cur_q << 1;
                    if (step_row[COLS-1]) step_dir = 1'b0;
                end else begin
                    step_row = cur_q >> 1;
                    if (step_row[0]) step_dir = 1'b1;
                end
            end else begin
                step_row = {cur_q[COLS-2:0], cur_q[COLS-1]};
            end
        end
    end

    // Overlap of the moving block with the locked row beneath it.
    always_comb begin
        prev_row = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (LW'(r) == (level_q - LW'(1))) prev_row = lock_q[r];
        end
        ov_next  = (level_q == '0) ? cur_q : (cur_q & prev_row);
        ov_width = popcount(ov_q);
    end

    // Game FSM: next state and next values of all game registers.
    always_comb begin
        state_d     = state_q;
        lock_d      = lock_q;
        cur_d       = cur_q;
        ov_d        = ov_q;
        width_d     = width_q;
        dir_d       = dir_q;
        level_d     = level_q;
        cnt_d       = cnt_q;
        game_over_d = game_over_q;
        win_d       = win_q;
        case (state_q)
            S_PLAY: begin
                if (press) begin
                    ov_d    = ov_next;
                    state_d = S_CHECK;
                end else if (step_due) begin
                    cnt_d = '0;
                    cur_d = step_row;
                    dir_d = step_dir;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_CHECK: begin
                if (ov_q == '0) begin
                    state_d     = S_LOST;
                    game_over_d = 1'b1;
                end else begin
                    for (int r = 0; r < ROWS; r++) begin
                        if (LW'(r) == level_q) lock_d[r] = ov_q;
                    end
                    if (level_q == LW'(ROWS - 1)) begin
                        state_d = S_WON;
                        win_d   = 1'b1;
                    end else begin
                        level_d = level_q + LW'(1);
                        width_d = ov_width;
                        cur_d   = low_ones(ov_width);
                        dir_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = S_PLAY;
                    end
                end
            end
            S_LOST, S_WON: begin
                if (press) begin
                    state_d     = S_PLAY;
                    lock_d      = '0;
                    cur_d       = START_ROW;
                    ov_d        = '0;
                    width_d     = START_W;
                    dir_d       = 1'b1;
                    level_d     = '0;
                    cnt_d       = '0;
                    game_over_d = 1'b0;
                    win_d       = 1'b0;
                end
            end
            default: state_d = S_PLAY;
        endcase
    end

    // State and datapath registers with synchronous reset on btnR.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (btnR) begin
            state_q     <= S_PLAY;
            // NOTE: the locked rows are a small set of flops, so they are reset so the frame starts clear.
            lock_q      <= '0;
            cur_q       <= START_ROW;
            ov_q        <= '0;
            width_q     <= START_W;
            dir_q       <= 1'b1;
            level_q     <= '0;
            cnt_q       <= '0;
            game_over_q <= 1'b0;
            win_q       <= 1'b0;
            btn_s_q     <= 1'b0;
            btn_prev_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            lock_q      <= lock_d;
            cur_q       <= cur_d;
            ov_q        <= ov_d;
            width_q     <= width_d;
            dir_q       <= dir_d;
            level_q     <= level_d;
            cnt_q       <= cnt_d;
            game_over_q <= game_over_d;
            win_q       <= win_d;
            btn_s_q     <= btnS;
            btn_prev_q  <= btn_s_q;
        end
    end

    // Frame: locked rows below the active row, moving block on it, blank above.
    always_comb begin
        map = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (LW'(r) < level_q) begin
                map[r*COLS +: COLS] = lock_q[r];
            end else if (LW'(r) == level_q) begin
                map[r*COLS +: COLS] = cur_q;
            end
        end
    end

    assign level     = level_q;
    assign game_over = game_over_q;
    assign win       = win_q;

endmodule
